keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
Drives the columns of a 4x4 membrane keypad and reads its rows. Debounces key presses and produces the 4-bit key code plus a one-cycle valid strobe. It is the encoder end of the keypad path and feeds the existing keypad code decoder directly, replacing an external encoder chip. Only one key is reported at a time; there is no key rollover.

Parameters:
SCAN_DIV, 50000, clock cycles per column dwell (1 ms at 50 MHz); minimum 4.
DEBOUNCE_SCANS, 8, consecutive matching dwell-end samples needed to accept a press or a release; range 1..255.
REPEAT_SCANS, 250, dwell periods between auto-repeat strobes; used only with KEYPAD_REPEAT_EN.

Ports:
clk  input  1  system clock; sole clock domain.
rst  input  1  synchronous, active-high reset.
row_n  input  4  keypad rows, active-low, externally pulled up, asynchronous to clk.
col_n  output  4  keypad column drive, active-low, one-hot-low.
key_code  output  4  encoded key, valid from key_valid onward.
key_valid  output  1  one-cycle strobe on an accepted press.
key_held  output  1  high while the accepted key is held, until the release is debounced.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Synchronise row_n with 2 flip-flops before any use.
- Dwell counter:
  - Counts 0..SCAN_DIV-1 and wraps.
  - The "sample" point is the cycle where the count equals SCAN_DIV-1.
  - All row decisions are made at sample points only.
- Reset values: col_n=4'b1110 (column 0), key_code=4'b0000, key_valid=0, key_held=0, state SCAN, all counters 0. Reset mid-operation takes effect at the next edge.
- Key code, with r = row index (0 = top) and c = column index (0 = left):
  - key_code[1:0] = ~{r[0],r[1]}
  - key_code[3:2] = {c[0],c[1]}
  - Examples: key 1 (r0,c0)=0011; key 5 (r1,c1)=1001; key 0 (r3,c1)=1000; * (r3,c0)=0000; # (r3,c2)=0100; A (r0,c3)=1111; D (r3,c3)=1100.
- FSM:
  - SCAN:
    - At a sample point with no synchronised row low: advance the column (3 wraps to 0).
    - If any row is low: latch the column and the lowest-indexed low row as the candidate, clear the debounce count, go to DEBOUNCE. The column is not advanced.
  - DEBOUNCE:
    - The column stays frozen.
    - At each sample, if the candidate row is low: count+1.
    - When the count reaches DEBOUNCE_SCANS: key_valid=1 in the next cycle, key_code updated in that same cycle, key_held=1, go to PRESSED.
    - If the candidate row is high at a sample: go to SCAN with no strobe, advancing the column.
  - PRESSED:
    - The column stays frozen; key_held=1.
    - Keys in other columns are ignored.
    - A candidate row high at a sample: go to RELEASE with count=1.
  - RELEASE:
    - Each high sample: count+1.
    - Any low sample: return to PRESSED with count cleared and no new strobe.
    - When the count reaches DEBOUNCE_SCANS: key_held=0, go to SCAN. The column advances at the next sample.
- Outputs:
  - key_valid is high for exactly 1 cycle per accepted press (without the optional feature).
  - key_code holds its value until the next strobe.
- Simultaneous keys:
  - Same column: the lowest row wins.
  - A key in another column is reported only after the current key is released and its column is scanned.
- Latency from the first low sample to key_valid: DEBOUNCE_SCANS*SCAN_DIV + 1 cycles.

Optional Feature:
KEYPAD_REPEAT_EN:
- When defined: in PRESSED, a repeat counter increments at each sample. Every REPEAT_SCANS samples it re-pulses key_valid for 1 cycle with the same key_code. The counter clears on entry to PRESSED and when returning to it from RELEASE.
- When undefined: exactly one strobe per press, and no repeat logic is synthesised.

Test Plan:
(Benches use SCAN_DIV=4 and DEBOUNCE_SCANS=3.)
1. Assert rst 2 cycles -> col_n=1110, key_code=0000, key_valid=0, key_held=0. Free-run with rows high -> col_n cycles 1110,1101,1011,0111,1110, each held 4 cycles.
2. Hold key 5 steady (row_n[1] low while col_n[1] low) -> exactly one key_valid pulse, key_code=1001, key_held=1, col_n frozen at 1101 for the whole hold.
3. Key 2 bounces (low for one sample, high at the next) -> no key_valid, scanning resumes. Then hold it stable -> single pulse, key_code=1011.
4. Press D, then release -> key_code=1100. key_held falls 3 samples after release. A single low glitch inside RELEASE -> key_held stays 1, no second pulse.
5. Rows 0 and 2 both low in column 2 -> key_code=0111 (key 3), one pulse.
6. rst asserted during PRESSED with the key still down -> outputs cleared next edge. After rst falls, the key is re-detected and one new pulse follows. With KEYPAD_REPEAT_EN and REPEAT_SCANS=5 -> a key_valid pulse every 20 cycles while held.

Source files
------------

// File: rtl/keypad_scanner.sv
// 4x4 membrane keypad scanner: drives one column low at a time, debounces row samples
// and emits a 4-bit key code with a one-cycle strobe. Define KEYPAD_REPEAT_EN for auto-repeat.
module keypad_scanner #(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 8,
    parameter int REPEAT_SCANS   = 250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int               DIV_W     = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCAN_DIV - 1);
    localparam logic [7:0]       DB_TARGET = 8'(DEBOUNCE_SCANS);

    generate
        if (SCAN_DIV < 4 || DEBOUNCE_SCANS < 1 || DEBOUNCE_SCANS > 255 || REPEAT_SCANS < 1) begin : g_bad_params
            $error("keypad_scanner: parameter out of range");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_DEBOUNCE,
        ST_PRESSED,
        ST_RELEASE
    } state_t;

    state_t           state_q;
    logic [3:0]       row_meta_q;
    logic [3:0]       row_sync_q;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;
    logic             sample;
    logic             cand_low;
    logic [1:0]       col_idx_q;
    logic [3:0]       col_n_q;
    logic [1:0]       cand_row_q;
    logic [7:0]       db_cnt_q;
    logic [3:0]       key_code_q;
    logic             key_valid_q;
    logic             key_held_q;

`ifdef KEYPAD_REPEAT_EN
    localparam int               REP_W    = $clog2(REPEAT_SCANS + 1);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_SCANS - 1);
    logic [REP_W-1:0]            rep_cnt_q;
`endif

    // Lowest-indexed low row wins when several rows in the same column are pressed.
    function automatic logic [1:0] lowest_low_row(input logic [3:0] rows_n);
        lowest_low_row = 2'd0;
        for (int r = 3; r >= 0; r--) begin
            if (!rows_n[r]) lowest_low_row = 2'(r);
        end
    endfunction

    // Bit layout expected by the downstream keypad code decoder.
    function automatic logic [3:0] encode_key(input logic [1:0] row, input logic [1:0] col);
        return {col[0], col[1], ~row[0], ~row[1]};
    endfunction

    always_comb begin
        sample   = (div_q == DIV_LAST);
        div_d    = sample ? '0 : div_q + 1'b1;
        cand_low = ~row_sync_q[cand_row_q];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_meta_q  <= 4'hF;
            row_sync_q  <= 4'hF;
            div_q       <= '0;
            state_q     <= ST_SCAN;
            col_idx_q   <= 2'd0;
            col_n_q     <= 4'b1110;
            cand_row_q  <= 2'd0;
            db_cnt_q    <= 8'd0;
            key_code_q  <= 4'b0000;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt_q   <= '0;
`endif
        end else begin
            row_meta_q  <= row_n;
            row_sync_q  <= row_meta_q;
            div_q       <= div_d;
            key_valid_q <= 1'b0;

            if (sample) begin
                unique case (state_q)
                    ST_SCAN: begin
                        if (&row_sync_q) begin
                            col_idx_q <= col_idx_q + 2'd1;
                            col_n_q   <= {col_n_q[2:0], col_n_q[3]};
                        end else begin
                            cand_row_q <= lowest_low_row(row_sync_q);
                            db_cnt_q   <= 8'd0;
                            state_q    <= ST_DEBOUNCE;
                        end
                    end

                    ST_DEBOUNCE: begin
                        if (cand_low) begin
                            if (db_cnt_q + 8'd1 == DB_TARGET) begin
                                key_valid_q <= 1'b1;
                                key_code_q  <= encode_key(cand_row_q, col_idx_q);
                                key_held_q  <= 1'b1;
                                db_cnt_q    <= 8'd0;
                                state_q     <= ST_PRESSED;
`ifdef KEYPAD_REPEAT_EN
                                rep_cnt_q   <= '0;
`endif
                            end else begin
                                db_cnt_q <= db_cnt_q + 8'd1;
                            end
                        end else begin
                            // Bounce: give up on this candidate and move on.
                            state_q   <= ST_SCAN;
                            col_idx_q <= col_idx_q + 2'd1;
                            col_n_q   <= {col_n_q[2:0], col_n_q[3]};
                        end
                    end

                    ST_PRESSED: begin
                        if (!cand_low) begin
                            if (DB_TARGET == 8'd1) begin
                                key_held_q <= 1'b0;
                                state_q    <= ST_SCAN;
                            end else begin
                                db_cnt_q <= 8'd1;
                                state_q  <= ST_RELEASE;
                            end
                        end
`ifdef KEYPAD_REPEAT_EN
                        else if (rep_cnt_q == REP_LAST) begin
                            rep_cnt_q   <= '0;
                            key_valid_q <= 1'b1;
                        end else begin
                            rep_cnt_q <= rep_cnt_q + 1'b1;
                        end
`endif
                    end

                    ST_RELEASE: begin
                        if (!cand_low) begin
                            if (db_cnt_q + 8'd1 == DB_TARGET) begin
                                key_held_q <= 1'b0;
                                db_cnt_q   <= 8'd0;
                                state_q    <= ST_SCAN;
                            end else begin
                                db_cnt_q <= db_cnt_q + 8'd1;
                            end
                        end else begin
                            // Glitch during release: key is still considered held.
                            db_cnt_q <= 8'd0;
                            state_q  <= ST_PRESSED;
`ifdef KEYPAD_REPEAT_EN
                            rep_cnt_q <= '0;
`endif
                        end
                    end

                    default: state_q <= ST_SCAN;
                endcase
            end
        end
    end

    assign col_n     = col_n_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a physical keypad matrix model drives the rows from col_n,
// a sample-level reference model is compared every cycle, and directed tests pin literals.
module tb_keypad_scanner;

    localparam int SCAN_DIV       = 4;
    localparam int DEBOUNCE_SCANS = 3;
    localparam int REPEAT_SCANS   = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] keys = '0;
    logic [3:0]  row_n;
    logic [3:0]  col_n;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;

    int errors = 0;
    int checks = 0;
    int pulses = 0;

    always #5 clk = ~clk;

    // Key at (row r, column c) is bit r*4+c; a pressed key shorts its row to a driven-low column.
    always_comb begin
        for (int r = 0; r < 4; r++) row_n[r] = ~|(keys[r*4 +: 4] & ~col_n);
    end

    keypad_scanner #(
        .SCAN_DIV      (SCAN_DIV),
        .DEBOUNCE_SCANS(DEBOUNCE_SCANS),
        .REPEAT_SCANS  (REPEAT_SCANS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .row_n    (row_n),
        .col_n    (col_n),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_held (key_held)
    );

    // ---------------- reference model ----------------
    localparam int M_SCAN = 0, M_DEB = 1, M_HELD = 2, M_REL = 3;

    int         m_col, m_mode, m_row, m_run, m_rep, m_tick;
    logic [3:0] m_code;
    logic       m_valid, m_held;
    logic [3:0] m_pipe[$];

    function automatic logic [3:0] spec_code(input int r, input int c);
        return 4'((c % 2) * 8 + (c / 2) * 4 + (1 - r % 2) * 2 + (1 - r / 2));
    endfunction

    function automatic int lowest(input logic [3:0] rows);
        for (int r = 0; r < 4; r++) if (!rows[r]) return r;
        return 0;
    endfunction

    always @(posedge clk) begin : model
        logic [3:0] seen;
        bit         at_sample;
        if (rst) begin
            m_pipe  = {4'hF, 4'hF};
            m_col   = 0;
            m_mode  = M_SCAN;
            m_row   = 0;
            m_run   = 0;
            m_rep   = 0;
            m_tick  = 0;
            m_code  = 4'h0;
            m_valid = 1'b0;
            m_held  = 1'b0;
        end else begin
            seen = m_pipe.pop_front();
            m_pipe.push_back(row_n);
            at_sample = (m_tick == SCAN_DIV - 1);
            m_tick    = (m_tick + 1) % SCAN_DIV;
            m_valid   = 1'b0;
            if (at_sample) begin
                case (m_mode)
                    M_SCAN: begin
                        if (seen == 4'hF) m_col = (m_col + 1) % 4;
                        else begin
                            m_row  = lowest(seen);
                            m_run  = 0;
                            m_mode = M_DEB;
                        end
                    end
                    M_DEB: begin
                        if (!seen[m_row]) begin
                            m_run++;
                            if (m_run == DEBOUNCE_SCANS) begin
                                m_valid = 1'b1;
                                m_code  = spec_code(m_row, m_col);
                                m_held  = 1'b1;
                                m_mode  = M_HELD;
                                m_rep   = 0;
                            end
                        end else begin
                            m_mode = M_SCAN;
                            m_col  = (m_col + 1) % 4;
                        end
                    end
                    M_HELD: begin
                        if (seen[m_row]) begin
                            m_run  = 1;
                            m_mode = M_REL;
                            if (m_run == DEBOUNCE_SCANS) begin
                                m_held = 1'b0;
                                m_mode = M_SCAN;
                            end
                        end
`ifdef KEYPAD_REPEAT_EN
                        else begin
                            m_rep++;
                            if (m_rep == REPEAT_SCANS) begin
                                m_rep   = 0;
                                m_valid = 1'b1;
                            end
                        end
`endif
                    end
                    default: begin
                        if (seen[m_row]) begin
                            m_run++;
                            if (m_run == DEBOUNCE_SCANS) begin
                                m_held = 1'b0;
                                m_mode = M_SCAN;
                            end
                        end else begin
                            m_run  = 0;
                            m_rep  = 0;
                            m_mode = M_HELD;
                        end
                    end
                endcase
            end
        end
    end

    always @(negedge clk) begin : compare
        logic [3:0] exp_col;
        exp_col = 4'hF ^ 4'(1 << m_col);
        checks++;
        if ({col_n, key_code, key_valid, key_held} !== {exp_col, m_code, m_valid, m_held}) begin
            errors++;
            $display("FAIL model t=%0t: col_n=%b key_code=%b key_valid=%b key_held=%b, expected %b %b %b %b",
                     $time, col_n, key_code, key_valid, key_held, exp_col, m_code, m_valid, m_held);
        end
    end

    // ---------------- directed tests ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        if (key_valid === 1'b1) pulses++;
    endtask

    task automatic wait_valid(input string name, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (key_valid !== 1'b1 && n < 400);
        if (key_valid !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL %s: key_valid not seen within %0d cycles", name, n);
        end
    endtask

    task automatic wait_held_low(input string name, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (key_held !== 1'b0 && n < 400);
        if (key_held !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL %s: key_held still high after %0d cycles", name, n);
        end
    endtask

    // Returns on the first cycle a fresh dwell of the target column begins.
    task automatic wait_col(input logic [3:0] target, input string name);
        int n;
        n = 0;
        while (col_n === target && n < 64) begin step(); n++; end
        n = 0;
        while (col_n !== target && n < 64) begin step(); n++; end
        if (col_n !== target) begin
            checks++;
            errors++;
            $display("FAIL %s: col_n=%b never reached %b", name, col_n, target);
        end
    endtask

    initial begin : stimulus
        int n, p0;

        // Reset and free-running scan
        rst  = 1'b1;
        keys = '0;
        step();
        step();
        check("reset col_n", col_n, 4'b1110);
        check("reset key_code", key_code, 4'b0000);
        check("reset key_valid", key_valid, 1'b0);
        check("reset key_held", key_held, 1'b0);
        rst = 1'b0;
        for (int i = 1; i < 20; i++) begin
            step();
            check("free-run col_n", col_n, 4'hF ^ 4'(1 << ((i / 4) % 4)));
        end

        // Key 5 held steady; column 1 starts on the next edge
        keys[5] = 1'b1;
        wait_col(4'b1101, "key5 column");
        p0 = pulses;
        wait_valid("key5", n);
        check("key5 latency", n, 16);
        check("key5 code", key_code, 4'b1001);
        check("key5 held", key_held, 1'b1);
        for (int i = 0; i < 40; i++) begin
            step();
            check("key5 col frozen", col_n, 4'b1101);
        end
`ifndef KEYPAD_REPEAT_EN
        check("key5 pulses", pulses - p0, 1);
`endif
        keys = '0;
        wait_held_low("key5 release", n);

        // Key 2 bounce: low at one sample, high at the next
        wait_col(4'b1101, "key2 column");
        p0 = pulses;
        keys[1] = 1'b1;
        repeat (4) step();
        keys = '0;
        repeat (4) step();
        check("key2 bounce resumes scan", col_n, 4'b1011);
        check("key2 bounce pulses", pulses - p0, 0);
        wait_col(4'b1101, "key2 column again");
        keys[1] = 1'b1;
        p0 = pulses;
        wait_valid("key2", n);
        check("key2 code", key_code, 4'b1011);
        repeat (10) step();
        check("key2 pulses", pulses - p0, 1);
        keys = '0;
        wait_held_low("key2 release", n);

        // Key D press, release right at the strobe
        keys[15] = 1'b1;
        p0 = pulses;
        wait_valid("keyD", n);
        check("keyD code", key_code, 4'b1100);
        keys = '0;
        wait_held_low("keyD release", n);
        check("keyD release delay", n, 12);
        check("keyD pulses", pulses - p0, 1);

        // Key D again with a one-cycle low glitch landing on the first RELEASE sample
        keys[15] = 1'b1;
        p0 = pulses;
        wait_valid("keyD2", n);
        keys = '0;
        repeat (5) step();
        keys[15] = 1'b1;
        step();
        keys = '0;
        repeat (8) step();
        check("keyD glitch keeps held", key_held, 1'b1);
        wait_held_low("keyD2 release", n);
        check("keyD glitch release delay", n, 6);
        check("keyD glitch pulses", pulses - p0, 1);

        // Rows 0 and 2 both low in column 2: key 3 wins
        keys[2]  = 1'b1;
        keys[10] = 1'b1;
        p0 = pulses;
        wait_valid("dual", n);
        check("dual code", key_code, 4'b0111);
        repeat (10) step();
        check("dual pulses", pulses - p0, 1);
        keys = '0;
        wait_held_low("dual release", n);

        // Reset while key A is held
        keys[3] = 1'b1;
        wait_valid("keyA", n);
        check("keyA code", key_code, 4'b1111);
        repeat (3) step();
        rst = 1'b1;
        step();
        check("mid-reset col_n", col_n, 4'b1110);
        check("mid-reset key_code", key_code, 4'b0000);
        check("mid-reset key_valid", key_valid, 1'b0);
        check("mid-reset key_held", key_held, 1'b0);
        rst = 1'b0;
        p0 = pulses;
        wait_valid("keyA after reset", n);
        check("keyA after reset code", key_code, 4'b1111);
        check("keyA after reset pulses", pulses - p0, 1);
`ifdef KEYPAD_REPEAT_EN
        wait_valid("keyA repeat", n);
        check("keyA repeat interval", n, SCAN_DIV * REPEAT_SCANS);
`endif
        keys = '0;
        wait_held_low("keyA release", n);
        repeat (8) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
